// File: rtl/mem_ttw_pkg.sv
// mem_ttw_pkg: sizing, entry type and line generator shared by mem_ttw_rsp and its sub-blocks
package mem_ttw_pkg;
  localparam int TTW_W = 2;
  localparam int MCN_W = 58;
  localparam int DEPTH = 4;
  localparam int LAT = 8;
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(LAT) + 1;
  typedef logic [TTW_W-1:0] ttw_t;
  typedef logic [MCN_W-1:0] mcn_t;
  typedef logic [511:0] line_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic vld;
    ttw_t idx;
    mcn_t mcn;
    cnt_t cnt;
  } ent_t;
  function automatic line_t gen_line(mcn_t mcn);
    line_t l;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = {3'(k), 3'b000, 58'(mcn)};
    return l;
  endfunction
endpackage

// File: rtl/mem_ttw_lfsr.sv
// mem_ttw_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1); ports clock, reset (sync active-low), lfsr
module mem_ttw_lfsr (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] lfsr
);
  always_ff @(posedge clock)
    lfsr <= !reset ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
endmodule

// File: rtl/mem_ttw_rsp.sv
// mem_ttw_rsp: fixed-latency in-order line responder for the walker mem_req/mem_res port; clock, reset (sync active-low), mem_req_i_* in, mem_res_o_* out, busy_o; MEM_TTW_RSP_STALL_EN adds LFSR-driven stalls
module mem_ttw_rsp
  import mem_ttw_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_req_i_valid,
  output logic       mem_req_i_ready,
  input  ttw_t       mem_req_i_bits_idx,
  input  mcn_t       mem_req_i_bits_mcn,
  input  logic       mem_res_o_ready,
  output logic       mem_res_o_valid,
  output ttw_t       mem_res_o_bits_idx,
  output line_t      mem_res_o_bits_data,
  output logic       busy_o
);
  ent_t q [DEPTH];
  logic [PTR_W-1:0] rd, wr;
  logic full, empty, push, pop, due;
  ent_t head;
  assign head = q[rd[PTR_W-2:0]];
  assign empty = rd == wr;
  assign full = (rd[PTR_W-1] != wr[PTR_W-1]) && (rd[PTR_W-2:0] == wr[PTR_W-2:0]);
  assign due = head.vld && head.cnt == '0;
`ifdef MEM_TTW_RSP_STALL_EN
  logic [15:0] lfsr;
  logic shown;
  mem_ttw_lfsr u_lfsr (.clock(clock), .reset(reset), .lfsr(lfsr));
  assign mem_req_i_ready = reset && !full && lfsr[0];
  // once offered, a response must stay up regardless of the LFSR
  assign mem_res_o_valid = due && (shown || !lfsr[1]);
  always_ff @(posedge clock)
    shown <= reset && mem_res_o_valid && !mem_res_o_ready;
`else
  assign mem_req_i_ready = reset && !full;
  assign mem_res_o_valid = due;
`endif
  assign push = mem_req_i_valid && mem_req_i_ready;
  assign pop = mem_res_o_valid && mem_res_o_ready;
  assign mem_res_o_bits_idx = mem_res_o_valid ? head.idx : '0;
  assign mem_res_o_bits_data = mem_res_o_valid ? gen_line(head.mcn) : '0;
  assign busy_o = !empty;
  always_ff @(posedge clock)
    if (!reset) begin
      rd <= '0;
      wr <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (q[i].vld && q[i].cnt != '0) q[i].cnt <= q[i].cnt - 1'b1;
      if (pop) begin
        q[rd[PTR_W-2:0]].vld <= 1'b0;
        rd <= rd + 1'b1;
      end
      if (push) begin
        q[wr[PTR_W-2:0]] <= '{vld: 1'b1, idx: mem_req_i_bits_idx, mcn: mem_req_i_bits_mcn, cnt: CNT_W'(LAT - 1)};
        wr <= wr + 1'b1;
      end
    end
endmodule

// File: tb/tb_mem_ttw_rsp.sv
// tb_mem_ttw_rsp: queue-model checker plus directed latency, backpressure, full and reset scenarios for mem_ttw_rsp
module tb_mem_ttw_rsp;
  localparam int LAT = 8;
  localparam int DEPTH = 4;
  logic clock = 0, reset = 0, req_valid = 0, res_ready = 0, rnd = 0;
  logic req_ready, res_valid, busy;
  logic [1:0] req_idx = '0, res_idx;
  logic [57:0] req_mcn = '0;
  logic [511:0] res_data;
  int total = 0, bad = 0, cyc = 0, npush = 0, npop = 0, nflush = 0, occ;
  typedef struct { logic [1:0] idx; logic [57:0] mcn; int n; } exp_t;
  exp_t q[$];
  logic pv = 0, pr = 0, prst = 0, ev;
  logic [1:0] pidx = '0;
  logic [511:0] pdata = '0;
  always #5 clock = ~clock;
  mem_ttw_rsp dut (
    .clock(clock), .reset(reset),
    .mem_req_i_valid(req_valid), .mem_req_i_ready(req_ready),
    .mem_req_i_bits_idx(req_idx), .mem_req_i_bits_mcn(req_mcn),
    .mem_res_o_ready(res_ready), .mem_res_o_valid(res_valid),
    .mem_res_o_bits_idx(res_idx), .mem_res_o_bits_data(res_data),
    .busy_o(busy)
  );
  function automatic logic [511:0] exp_line(logic [57:0] m);
    logic [511:0] l = '0;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = (64'(k) << 61) | {6'd0, m};
    return l;
  endfunction
  task automatic chk(string nm, logic [511:0] a, logic [511:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    if (rnd) res_ready = 1'($urandom_range(1));
  endtask
  task automatic push(input logic [1:0] i, input logic [57:0] m, output int n);
    int t = 0;
    req_valid = 1; req_idx = i; req_mcn = m;
    while (!req_ready && t < 300) begin step(); t++; end
    if (!req_ready) begin total++; bad++; $display("FAIL push_timeout ready=0 want=1"); end
    n = cyc;
    step();
    req_valid = 0;
  endtask
  task automatic wait_valid(output int c);
    int t = 0;
    while (!res_valid && t < 300) begin step(); t++; end
    if (!res_valid) begin total++; bad++; $display("FAIL wait_valid_timeout valid=0 want=1"); end
    c = cyc;
  endtask
  task automatic drain();
    int t = 0;
    rnd = 0; res_ready = 1;
    while ((busy || q.size() != 0) && t < 500) begin step(); t++; end
    chk("drain_busy", busy, 0);
    chk("drain_model_empty", q.size(), 0);
    chk("drain_counts", npush, npop + nflush);
  endtask
  always @(negedge clock) begin
    occ = q.size();
`ifdef MEM_TTW_RSP_STALL_EN
    if (req_ready) chk("ready_room", reset && occ < DEPTH, 1);
    if (res_valid) chk("valid_due", occ > 0 && cyc >= q[0].n + LAT, 1);
`else
    ev = occ > 0 && cyc >= q[0].n + LAT;
    chk("ready", req_ready, reset && occ < DEPTH);
    chk("valid", res_valid, ev);
`endif
    chk("busy", busy, occ > 0);
    if (res_valid && occ > 0) begin
      chk("res_idx", res_idx, q[0].idx);
      chk("res_data", res_data, exp_line(q[0].mcn));
    end else if (!res_valid) begin
      chk("idle_idx", res_idx, 0);
      chk("idle_data", res_data, 0);
    end
    if (pv && !pr && prst) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_idx", res_idx, pidx);
      chk("hold_data", res_data, pdata);
    end
    pv = res_valid; pr = res_ready; prst = reset; pidx = res_idx; pdata = res_data;
    if (!reset) begin
      nflush += occ;
      q.delete();
    end else begin
      if (res_valid && res_ready && occ > 0) begin q.delete(0); npop++; end
      if (req_valid && req_ready) begin q.push_back('{req_idx, req_mcn, cyc}); npush++; end
    end
    cyc++;
  end
  initial begin
    int n, c, x, nv;
    logic [511:0] d;
    reset = 0;
    repeat (3) step();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", res_data, 0);
    reset = 1;
    step();
`ifndef MEM_TTW_RSP_STALL_EN
    chk("post_rst_ready", req_ready, 1);
    res_ready = 1;
    push(2'd1, 58'h123, n);
    wait_valid(c);
    chk("t1_lat", c - n, 8);
    chk("t1_idx", res_idx, 1);
    chk("t1_w0", res_data[63:0], 64'h0000_0000_0000_0123);
    chk("t1_w7", res_data[511:448], 64'hE000_0000_0000_0123);
    step();
    chk("t1_busy", busy, 0);
    push(2'd0, 58'h40, n);
    for (int i = 1; i < 4; i++) push(2'(i), 58'h40 + 58'(i), x);
    chk("t2_full_ready", req_ready, 0);
    wait_valid(c);
    chk("t2_lat", c - n, 8);
    chk("t2_ready_n8", req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) chk("t2_ready_n9", req_ready, 1);
      chk("t2_order", res_idx, i);
      step();
    end
    chk("t2_busy", busy, 0);
    res_ready = 0;
    push(2'd2, 58'h3ff_ffff_ffff_ffff, n);
    wait_valid(c);
    d = res_data;
    chk("t3_w3", d[255:192], 64'h63ff_ffff_ffff_ffff);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t3_valid", res_valid, 1);
      chk("t3_data", res_data, d);
    end
    res_ready = 1;
    step();
    chk("t3_popped", busy, 0);
    res_ready = 0;
    for (int i = 0; i < 4; i++) push(2'(i), 58'h100 + 58'(i), x);
    wait_valid(c);
    res_ready = 1; req_valid = 1; req_idx = 2'd2; req_mcn = 58'h77;
    chk("t4_ready_m", req_ready, 0);
    step();
    chk("t4_ready_m1", req_ready, 1);
    step();
    req_valid = 0;
    drain();
    res_ready = 1;
    for (int i = 1; i < 4; i++) push(2'(i), 58'h200 + 58'(i), x);
    step(); step();
    reset = 0;
    step(); step();
    reset = 1;
    nv = 0;
    for (int i = 0; i < 15; i++) begin step(); nv += int'(res_valid); end
    chk("t5_no_resp", nv, 0);
    push(2'd3, 58'h5, n);
    wait_valid(c);
    chk("t5_lat", c - n, 8);
    chk("t5_idx", res_idx, 3);
    chk("t5_w0", res_data[63:0], 64'h0000_0000_0000_0005);
    chk("t5_w5", res_data[383:320], 64'hA000_0000_0000_0005);
    step();
    rnd = 1;
    for (int i = 0; i < 300; i++)
      if ($urandom_range(3) == 0) step();
      else push(2'($urandom_range(3)), 58'({$urandom(), $urandom()}), x);
`else
    rnd = 1;
    for (int i = 0; i < 1000; i++) push(2'($urandom_range(3)), 58'({$urandom(), $urandom()}), x);
`endif
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_ttw_rsp.md
Name: mem_ttw_rsp

Overview:
- Synthesizable memory responder for the table-walker memory port; it is the slave end of the mem_req/mem_res channel that the walker drives.
- Accepts line-fetch requests (idx, mcn) and queues them in order.
- Returns each request after a fixed latency as a 512-bit line generated deterministically from the mcn.
- Used in the fs bench and in FPGA bring-up in place of the real LLC.

Parameters:
- TTW_W, 2, width of request/response idx (matches tb_base::ttw_t)
- MCN_W, 58, width of the memory cache-line number
- DEPTH, 4, request queue entries (power of 2, >=2)
- LAT, 8, cycles from acceptance to earliest response valid (>=1)

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low reset
- mem_req_i_valid  in  1  request valid
- mem_req_i_ready  out  1  request accepted when valid&&ready
- mem_req_i_bits_idx  in  TTW_W  walker slot tag
- mem_req_i_bits_mcn  in  MCN_W  line number
- mem_res_o_ready  in  1  walker accepts response
- mem_res_o_valid  out  1  response valid
- mem_res_o_bits_idx  out  TTW_W  tag echoed from request
- mem_res_o_bits_data  out  512  line data
- busy_o  out  1  queue non-empty

Behaviour:
- Reset (reset==0 at clock edge):
  - queue flushed; rd/wr pointers cleared; entries invalidated.
  - Outputs during/after reset: mem_req_i_ready=0 while reset==0, then 1; mem_res_o_valid=0; idx/data=0; busy_o=0.
  - Reset mid-operation drops all in-flight requests silently.
- Queue: circular, ptr width clog2(DEPTH)+1; full when ptr MSBs differ and low bits equal; empty when equal.
- mem_req_i_ready = !full (registered-free, combinational from pointers). No push-on-pop bypass: a full queue stays not-ready in the cycle it pops.
- Push: on fire, the entry stores idx, mcn, and cnt=LAT-1 (width clog2(LAT)+1).
- Countdown: every valid entry with cnt!=0 decrements each cycle, independent of position.
- Timing: a request accepted in cycle N gives earliest mem_res_o_valid in cycle N+LAT. LAT=1 gives the next cycle.
- Response:
  - mem_res_o_valid = head valid && head cnt==0.
  - bits are driven combinationally from the head entry.
  - Once valid, valid and bits stay stable until mem_res_o_ready; no retraction.
  - Pop on valid&&ready.
- Ordering: strictly in order; responses never overtake.
- Data rule: 64-bit word k (k=0..7, word 0 at bits [63:0]) = {k[2:0], 3'b000, mcn[57:0]}; for MCN_W<58, mcn is zero-extended.
- Simultaneous push and pop are both honoured in one cycle; occupancy is unchanged.
- busy_o = !empty.

Optional Feature:
- MEM_TTW_RSP_STALL_EN:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset), advancing every cycle.
  - mem_req_i_ready = !full && lfsr[0].
  - A head whose countdown has expired is additionally held invalid while lfsr[1]==1; once valid is asserted it stays asserted (stability rule unchanged).
- Without the macro: no LFSR; ready and valid follow the base rules above.

Decomposition:
- Package mem_ttw_pkg:
  - typedefs ttw_t (TTW_W), mcn_t (MCN_W), line_t (512);
  - struct ent_t {vld, idx, mcn, cnt};
  - function gen_line(mcn_t) implementing the data rule.
- Sub-module mem_ttw_lfsr: LFSR, instantiated only under MEM_TTW_RSP_STALL_EN.

Test Plan:
- Single request idx=1, mcn=58'h123 accepted cycle 10, res_ready=1 → valid in cycle 18, idx=1; word0=64'h0000_0000_0000_0123, word7=64'hE000_0000_0000_0123; busy_o drops cycle 19.
- Four back-to-back requests idx 0..3, res_ready=1 → mem_req_i_ready=0 after the fourth; responses in cycles N+8..N+11 in order 0,1,2,3; ready returns cycle N+9.
- Response backpressure: res_ready=0 for 20 cycles after valid → valid, idx and data stable throughout; pop occurs on the first ready cycle.
- Full queue with simultaneous pop: DEPTH=4 full, pop in cycle M → ready=0 in M, 1 in M+1; no request is lost or duplicated.
- Reset asserted with 3 entries in flight → no response is emitted for them; after reset, a new request mcn=58'h5 returns exactly LAT cycles after acceptance with correct data.
- MEM_TTW_RSP_STALL_EN, 1000 random requests → every request receives exactly one response, in order, with correct data; no valid retraction.
